des_decrypt_iter: RTL and testbench

DES_DECRYPT_ITER -- requirements
Module: des_decrypt_iter

---
 rtl/des_decrypt_iter.sv | 105 ++++++++++
 tb/tb_des_decrypt_iter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, subkeys 16..1.
// F function and key schedule live outside; this block holds L/R and sequences rounds.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready for a new L0||R0 block
//   ROUND | one Feistel round per edge, cnt counts subkey index 15..0
//   DONE  | R16||L16 presented on data_out until downstream takes it
module des_decrypt_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [64:1] data_in,
    output logic [4:1]  round_sel,
    output logic [32:1] f_r,
    input  logic [32:1] f_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:1] data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [32:1] l;
    logic [32:1] r;
    logic [4:1]  cnt;
    logic        load;
    logic        step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // in_valid is deliberately ignored here; the input waits for IDLE
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // cnt stops at 0 on the last round so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l   <= 32'h0;
            r   <= 32'h0;
            cnt <= 4'd0;
        end else if (load) begin
            l   <= data_in[64:33];
            r   <= data_in[32:1];
            cnt <= 4'd15;
        end else if (step) begin
            l <= r;
            r <= l ^ f_out;
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    assign round_sel = cnt;
    assign f_r       = r;
    assign data_out  = out_valid ? {r, l} : 64'h0;

endmodule

// File: tb/tb_des_decrypt_iter.sv
// Directed bench for des_decrypt_iter with a reference DES F function and key schedule
// driving f_out, so full decryptions can be checked against known vectors.
module tb_des_decrypt_iter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [64:1] data_in;
    logic [4:1]  round_sel;
    logic [32:1] f_r;
    logic [32:1] f_out;
    logic        out_valid;
    logic        out_ready;
    logic [64:1] data_out;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int f_mode;
    logic [47:0] subkey [16];

    localparam logic [63:0] DES_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] DES_CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] DES_PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] SEQ_EXP = 64'hFEDCBA9876543210;

    localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                                  10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                                  14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
    localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                                  23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
    localparam int SHIFT_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int SB [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

    des_decrypt_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .round_sel (round_sel),
        .f_r       (f_r),
        .f_out     (f_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    // Table positions are DES-style: 1 is the MSB
    function automatic int ip_entry(input int i);
        int row;
        row = i / 8;
        return ((row < 4) ? (58 + 2 * row) : (49 + 2 * row)) - 8 * (i % 8);
    endfunction

    function automatic int e_entry(input int i);
        return ((4 * (i / 6) + (i % 6) + 31) % 32) + 1;
    endfunction

    function automatic logic [63:0] ip_fn(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - ip_entry(i))];
        return y;
    endfunction

    function automatic logic [63:0] fp_fn(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[6'(64 - ip_entry(i))] = x[6'(63 - i)];
        return y;
    endfunction

    function automatic logic [31:0] des_f(input logic [31:0] rr, input logic [47:0] k);
        logic [47:0] e;
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] p;
        logic [5:0]  b6;
        int          row;
        int          col;
        e = '0;
        s = '0;
        p = '0;
        for (int i = 0; i < 48; i++) e[6'(47 - i)] = rr[5'(32 - e_entry(i))];
        x = e ^ k;
        for (int b = 0; b < 8; b++) begin
            b6  = 6'(x >> (42 - 6 * b));
            row = 2 * int'(b6[5]) + int'(b6[0]);
            col = int'(b6[4:1]);
            s   = {s[27:0], 4'(SB[9'(b * 64 + row * 16 + col)])};
        end
        for (int i = 0; i < 32; i++) p[5'(31 - i)] = s[5'(32 - P_T[i])];
        return p;
    endfunction

    always_comb begin
        case (f_mode)
            0:       f_out = 32'h0;
            1:       f_out = 32'hFFFF_FFFF;
            default: f_out = des_f(f_r, subkey[round_sel]);
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from the sample just after acceptance until out_valid, bounded at 40 edges
    task automatic wait_done(output logic [63:0] dout, output int lat, output logic [63:0] seq);
        lat = 0;
        seq = '0;
        while (!out_valid && lat < 40) begin
            seq = {seq[59:0], round_sel};
            tick();
            lat++;
        end
        dout = data_out;
    endtask

    task automatic run_block(input string tag, input logic [63:0] din,
                             output logic [63:0] dout, output int lat, output logic [63:0] seq);
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        data_in  = din;
        tick();
        in_valid = 1'b0;
        wait_done(dout, lat, seq);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_data_out"},  64'(data_out),  64'd0);
        chk({tag, "_round_sel"}, 64'(round_sel), 64'd0);
        chk({tag, "_f_r"},       64'(f_r),       64'd0);
    endtask

    initial begin
        logic [55:0] cd;
        logic [55:0] both;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] sk;
        logic [63:0] dout;
        logic [63:0] seq;
        int          lat;
        int          highs;
        int          pulses [$];
        int          p0;
        int          p1;
        int          p2;

        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = DES_KEY[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int rnd = 0; rnd < 16; rnd++) begin
            for (int s = 0; s < SHIFT_T[rnd]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            both = {c, d};
            for (int i = 0; i < 48; i++) sk[6'(47 - i)] = both[6'(56 - PC2_T[i])];
            subkey[rnd] = sk;
        end

        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        f_mode    = 0;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        tick();
        tick();
        #2 rst_n = 1'b1;

        // F = 0: sixteen pure swaps bring the halves back, output swaps them
        run_block("f0", 64'h0123456789ABCDEF, dout, lat, seq);
        chk("f0_data", dout, 64'h89ABCDEF01234567);
        chk("f0_latency", 64'(lat), 64'd16);
        chk("f0_round_seq", seq, SEQ_EXP);
        chk("f0_busy_done", 64'(busy), 64'd1);
        handshake();
        chk("f0_after_valid", 64'(out_valid), 64'd0);
        chk("f0_after_data", 64'(data_out), 64'd0);
        chk("f0_after_ready", 64'(in_ready), 64'd1);
        chk("f0_after_busy", 64'(busy), 64'd0);

        // F = all ones: period-4 rotation over 16 rounds
        f_mode = 1;
        run_block("f1", 64'h0123456789ABCDEF, dout, lat, seq);
        chk("f1_data", dout, 64'h89ABCDEF01234567);
        chk("f1_latency", 64'(lat), 64'd16);
        handshake();

        f_mode = 2;
        run_block("des", ip_fn(DES_CT), dout, lat, seq);
        chk("des_plain", fp_fn(dout), DES_PT);
        chk("des_round_seq", seq, SEQ_EXP);
        handshake();

        // Output stall with a competing input request
        f_mode = 0;
        run_block("stall", 64'h0011223344556677, dout, lat, seq);
        chk("stall_data", dout, 64'h4455667700112233);
        in_valid = 1'b1;
        data_in  = 64'hA5A5A5A55A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_hold_data", 64'(data_out), 64'h4455667700112233);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("stall_hs_valid", 64'(out_valid), 64'd0);
        chk("stall_hs_not_taken", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("stall_accept_busy", 64'(busy), 64'd1);
        chk("stall_accept_sel", 64'(round_sel), 64'd15);
        chk("stall_accept_fr", 64'(f_r), 64'h5A5A5A5A);
        wait_done(dout, lat, seq);
        chk("stall_next_data", dout, 64'h5A5A5A5AA5A5A5A5);
        chk("stall_next_latency", 64'(lat), 64'd16);
        handshake();

        // Reset in round 7 (subkey index 9), asserted between clock edges
        f_mode   = 2;
        in_valid = 1'b1;
        data_in  = 64'hDEADBEEFCAFEF00D;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("abort_round7_sel", 64'(round_sel), 64'd9);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        #2 rst_n = 1'b1;
        run_block("post_abort", ip_fn(DES_CT), dout, lat, seq);
        chk("post_abort_plain", fp_fn(dout), DES_PT);
        chk("post_abort_latency", 64'(lat), 64'd16);
        handshake();

        // Back-to-back: 18-cycle period, one-cycle out_valid pulses
        f_mode    = 0;
        data_in   = 64'hFEDCBA9876543210;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        highs     = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (out_valid) begin
                highs++;
                pulses.push_back(i);
                chk("b2b_data", 64'(data_out), 64'h76543210FEDCBA98);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p0 = (pulses.size() > 0) ? pulses[0] : -1;
        p1 = (pulses.size() > 1) ? pulses[1] : -1;
        p2 = (pulses.size() > 2) ? pulses[2] : -1;
        chk("b2b_pulse_count", 64'(highs), 64'd3);
        chk("b2b_first_pulse", 64'(p0), 64'd17);
        chk("b2b_period_1", 64'(p1 - p0), 64'd18);
        chk("b2b_period_2", 64'(p2 - p1), 64'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
